// File: rtl/pipe_stage_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_if
// Purpose : valid/ready/data handshake bundle used on both sides of a
//           pipeline stage register. One instance carries the upstream
//           (producer -> stage) link, another the downstream
//           (stage -> consumer) link.
// Signals : valid  producer has a live payload on data
//           ready  consumer can take the payload this cycle
//           data   payload, PWL bits wide
// Modports: master  producer side (drives valid/data, samples ready)
//           slave   consumer side (samples valid/data, drives ready)
// ---------------------------------------------------------------------------
interface pipe_stage_skid_if #(
    parameter int PWL = 128
);
    logic           valid;
    logic           ready;
    logic [PWL-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Purpose : pipeline-stage register with a valid/ready handshake and a
//           2-entry skid buffer, a synchronous flush and a saturating stall
//           counter. Both ready towards upstream and the downstream
//           valid/data are driven straight from flops, so no combinational
//           path crosses the stage in either direction.
// Parameters:
//   PWL    payload width (control + data fields of one stage)
//   CNT_W  width of the saturating stall counter
// Ports   :
//   i_clk        clock, all state on the rising edge
//   i_clr_n      asynchronous active-low reset
//   i_flush      synchronous flush, drops every held entry
//   s_in         upstream link (slave): valid/data in, ready out
//   m_out        downstream link (master): valid/data out, ready in
//   o_occ        number of held entries (0, 1 or 2)
//   o_stall_cnt  cycles with downstream valid high and ready low, saturating
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int PWL   = 128,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic             i_flush,
    pipe_stage_skid_if.slave  s_in,
    pipe_stage_skid_if.master m_out,
    output logic [1:0]       o_occ,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // The state encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_nextState;
    logic [PWL-1:0]   r_main;
    logic [PWL-1:0]   r_skid;
    logic [PWL-1:0]   w_mainNext;
    logic [PWL-1:0]   w_skidNext;
    logic             r_inReady;
    logic             r_outValid;
    logic [CNT_W-1:0] r_stallCnt;
    logic             w_inFire;
    logic             w_outFire;
    logic             w_stall;

    assign w_inFire  = s_in.valid & r_inReady;
    assign w_outFire = r_outValid & m_out.ready;
    assign w_stall   = r_outValid & ~m_out.ready;

    assign s_in.ready   = r_inReady;
    assign m_out.valid  = r_outValid;
    assign m_out.data   = r_main;
    assign o_occ        = r_state;
    assign o_stall_cnt  = r_stallCnt;

    // Next-state and next-storage decode. Flush wins over any handshake
    // in the same cycle, so a payload that looked accepted is discarded.
    // In FULL the registered ready is low, so no in_fire is possible there.
    always_comb begin
        w_nextState = r_state;
        w_mainNext  = r_main;
        w_skidNext  = r_skid;

        if (i_flush) begin
            w_nextState = EMPTY;
            w_mainNext  = '0;
            w_skidNext  = '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_inFire) begin
                        w_nextState = ONE;
                        w_mainNext  = s_in.data;
                    end
                end
                ONE: begin
                    if (w_inFire && w_outFire) begin
                        w_nextState = ONE;
                        w_mainNext  = s_in.data;
                    end else if (w_inFire) begin
                        w_nextState = FULL;
                        w_skidNext  = s_in.data;
                    end else if (w_outFire) begin
                        w_nextState = EMPTY;
                    end
                end
                FULL: begin
                    if (w_outFire) begin
                        w_nextState = ONE;
                        w_mainNext  = r_skid;
                        w_skidNext  = '0;
                    end
                end
                default: begin
                    w_nextState = EMPTY;
                    w_mainNext  = '0;
                    w_skidNext  = '0;
                end
            endcase
        end
    end

    // State, storage and the handshake flags. Ready and valid are computed
    // from the next state so they come straight out of flops next cycle.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state    <= EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_main     <= w_mainNext;
            r_skid     <= w_skidNext;
            r_inReady  <= (w_nextState != FULL);
            r_outValid <= (w_nextState != EMPTY);
        end
    end

    // Stall counter: counts every cycle a live entry is refused downstream,
    // flush cycles included, and is cleared only by reset.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_stallCnt <= '0;
        end else if (w_stall && (r_stallCnt != CNT_MAX)) begin
            r_stallCnt <= r_stallCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
// Purpose : self-checking bench for pipe_stage_skid. A queue-based model of
//           the stage is advanced on every rising edge; a compare process
//           checks all DUT outputs against it on every falling edge. Directed
//           sections add literal expectations for reset, streaming, skid,
//           flush and counter saturation, followed by a random run.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int PWL   = 64;
    localparam int CNT_W = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk;
    logic             clrN;
    logic             flush;
    logic [1:0]       occ;
    logic [CNT_W-1:0] stallCnt;

    pipe_stage_skid_if #(.PWL(PWL)) upIf ();
    pipe_stage_skid_if #(.PWL(PWL)) dnIf ();

    pipe_stage_skid #(
        .PWL   (PWL),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_clr_n     (clrN),
        .i_flush     (flush),
        .s_in        (upIf),
        .m_out       (dnIf),
        .o_occ       (occ),
        .o_stall_cnt (stallCnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the held entries as a plain FIFO of depth 2, the
    // value the output register should show, and the saturating counter.
    logic [PWL-1:0] mQueue[$];
    logic [PWL-1:0] mOut = '0;
    int             mCnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then land on the following falling edge.
    task automatic applyStimulus(input logic v, input logic [PWL-1:0] d,
                                 input logic r, input logic f);
        upIf.valid = v;
        upIf.data  = d;
        dnIf.ready = r;
        flush      = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset pulse placed between edges; the async clear is checked at once.
    task automatic resetPulse();
        #1 clrN = 1'b0;
        #1;
        checkOutput("async_rst_valid", {63'd0, dnIf.valid}, 64'd0);
        checkOutput("async_rst_occ", {62'd0, occ}, 64'd0);
        checkOutput("async_rst_data", dnIf.data, 64'd0);
        #1 clrN = 1'b1;
        @(negedge clk);
    endtask

    // Model update on each edge, using the model's own occupancy for fires.
    initial begin
        forever begin
            @(posedge clk or negedge clrN);
            if (!clrN) begin
                mQueue.delete();
                mOut = '0;
                mCnt = 0;
            end else begin
                bit inFire;
                bit outFire;
                if (mQueue.size() > 0 && !dnIf.ready && mCnt < CNT_SAT)
                    mCnt++;
                if (flush) begin
                    mQueue.delete();
                    mOut = '0;
                end else begin
                    inFire  = upIf.valid && (mQueue.size() < 2);
                    outFire = (mQueue.size() > 0) && dnIf.ready;
                    if (outFire) void'(mQueue.pop_front());
                    if (inFire) mQueue.push_back(upIf.data);
                    if (mQueue.size() > 0) mOut = mQueue[0];
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model_in_ready", {63'd0, upIf.ready},
                        {63'd0, (mQueue.size() < 2)});
            checkOutput("model_out_valid", {63'd0, dnIf.valid},
                        {63'd0, (mQueue.size() > 0)});
            checkOutput("model_occ", {62'd0, occ}, 64'(mQueue.size()));
            checkOutput("model_out_data", dnIf.data, mOut);
            checkOutput("model_stall_cnt", {60'd0, stallCnt}, 64'(mCnt));
        end
    end

    initial begin
        clrN       = 1'b0;
        flush      = 1'b0;
        upIf.valid = 1'b1;
        upIf.data  = 64'hDEAD_BEEF;
        dnIf.ready = 1'b0;

        // 1: reset held with valid input offered, nothing captured.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_in_ready", {63'd0, upIf.ready}, 64'd1);
            checkOutput("rst_out_valid", {63'd0, dnIf.valid}, 64'd0);
            checkOutput("rst_out_data", dnIf.data, 64'd0);
            checkOutput("rst_occ", {62'd0, occ}, 64'd0);
            checkOutput("rst_stall", {60'd0, stallCnt}, 64'd0);
        end
        #1 clrN = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 64'hDEAD_BEEF, 1'b0, 1'b0);
        checkOutput("post_rst_capture", dnIf.data, 64'hDEAD_BEEF);

        // 2: streaming with downstream always ready.
        resetPulse();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 64'(k), 1'b1, 1'b0);
            checkOutput("stream_data", dnIf.data, 64'(k));
            checkOutput("stream_occ", {62'd0, occ}, 64'd1);
        end
        checkOutput("stream_stall", {60'd0, stallCnt}, 64'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("stream_drain_valid", {63'd0, dnIf.valid}, 64'd0);

        // 3: skid - fill with A and B while blocked, then release.
        applyStimulus(1'b1, 64'hAAAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hBBBB, 1'b0, 1'b0);
        checkOutput("skid_occ_full", {62'd0, occ}, 64'd2);
        checkOutput("skid_in_ready", {63'd0, upIf.ready}, 64'd0);
        checkOutput("skid_hold_a", dnIf.data, 64'hAAAA);
        applyStimulus(1'b1, 64'hEEEE, 1'b0, 1'b0);
        checkOutput("skid_refuse", dnIf.data, 64'hAAAA);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("skid_b_out", dnIf.data, 64'hBBBB);
        checkOutput("skid_ready_back", {63'd0, upIf.ready}, 64'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("skid_empty", {62'd0, occ}, 64'd0);

        // 4: flush while full with C offered; C must never appear.
        applyStimulus(1'b1, 64'hAAAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hBBBB, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hCCCC, 1'b0, 1'b1);
        checkOutput("flush_occ", {62'd0, occ}, 64'd0);
        checkOutput("flush_valid", {63'd0, dnIf.valid}, 64'd0);
        checkOutput("flush_data", dnIf.data, 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("flush_no_c", {63'd0, dnIf.valid}, 64'd0);
        end

        // 5: counter saturation, survives flush, cleared by reset.
        resetPulse();
        applyStimulus(1'b1, 64'h1234, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("cnt_saturated", {60'd0, stallCnt}, 64'd15);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("cnt_after_flush", {60'd0, stallCnt}, 64'd15);
        resetPulse();
        checkOutput("cnt_after_reset", {60'd0, stallCnt}, 64'd0);

        // 6: random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 10000; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, {$urandom, $urandom},
                          $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
